alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the team's combinational 32-bit ALU.
- Accepts one operation per transaction on a valid/ready input port and returns a registered result plus status flags on a valid/ready output port.
- Adds an iterative multi-cycle unsigned multiply and a shift-left op, and holds results under backpressure.
- Sits between the datapath register read stage and writeback.

---
 rtl/alu_pipe.sv | 150 +++++++++++++++
 tb/tb_alu_pipe.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shift-add multiply,
// results held in a registered output stage until the consumer takes them.
module alu_pipe #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             overflow,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
   typedef enum logic [2:0] {
      OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
      OP_XOR = 3'b100, OP_GT  = 3'b101, OP_MUL = 3'b110, OP_SLL = 3'b111
   } op_t;

   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   state_t             r_state;
   logic [WIDTH-1:0]   r_result;
   logic               r_zero;
   logic               r_carry;
   logic               r_overflow;
   logic               r_out_valid;
   logic               r_busy;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [SHW-1:0]     r_cnt;

   op_t                w_op;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_res;
   logic               w_c;
   logic               w_v;
   logic [2*WIDTH-1:0] w_acc_next;

   assign w_op       = op_t'(sel);
   assign w_sum      = {1'b0, a} + {1'b0, b};
   assign w_diff     = {1'b0, a} - {1'b0, b};
   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Single-cycle ops; MUL result comes from the iterative datapath instead.
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  w_res = a & b;
         OP_OR:   w_res = a | b;
         OP_XOR:  w_res = a ^ b;
         OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (a > b)};
         OP_SLL:  w_res = a << b[SHW-1:0];
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_carry     <= 1'b0;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  if (w_op == OP_MUL) begin
                     r_mcand  <= {{WIDTH{1'b0}}, a};
                     r_mplier <= b;
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_busy   <= 1'b1;
                     r_state  <= S_MUL;
                  end else begin
                     r_result    <= w_res;
                     r_zero      <= (w_res == '0);
                     r_carry     <= w_c;
                     r_overflow  <= w_v;
                     r_out_valid <= 1'b1;
                     r_state     <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               // Multiplier consumed LSB-first; the last step publishes w_acc_next directly.
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + SHW'(1);
               if (r_cnt == LAST) begin
                  r_result    <= w_acc_next[WIDTH-1:0];
                  r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
                  r_carry     <= 1'b0;
                  r_overflow  <= |w_acc_next[2*WIDTH-1:WIDTH];
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign zero      = r_zero;
   assign carry     = r_carry;
   assign overflow  = r_overflow;
   assign busy      = r_busy;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: an 8-bit instance for arithmetic/multiply/flow
// control scenarios and a 32-bit instance for legacy ops and random traffic.
module tb_alu_pipe;

   typedef struct {
      logic [63:0] res;
      logic        z;
      logic        c;
      logic        v;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;

   logic       iv8, ir8, ov8, ordy8, z8, c8, v8, b8;
   logic [7:0] a8, bb8, res8;
   logic [2:0] s8;

   logic        iv32, ir32, ov32, ordy32, z32, c32, v32, b32;
   logic [31:0] a32, bb32, res32;
   logic [2:0]  s32;

   exp_t q8[$];
   exp_t q32[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(bb8),
      .sel(s8), .out_valid(ov8), .out_ready(ordy8), .result(res8), .zero(z8),
      .carry(c8), .overflow(v8), .busy(b8)
   );

   alu_pipe #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(bb32),
      .sel(s32), .out_valid(ov32), .out_ready(ordy32), .result(res32), .zero(z32),
      .carry(c32), .overflow(v32), .busy(b32)
   );

   // Reference computed with wide integer arithmetic and signed range checks.
   function automatic exp_t model(input int unsigned w, input logic [63:0] a,
                                  input logic [63:0] b, input logic [2:0] sel);
      exp_t e;
      longint unsigned mask, ua, ub, hu, full;
      longint sa, sb, ss, half;
      mask = (64'd1 << w) - 64'd1;
      ua   = a & mask;
      ub   = b & mask;
      hu   = 64'd1 << (w - 1);
      half = longint'(hu);
      sa   = longint'(ua);
      sb   = longint'(ub);
      if (ua >= hu) sa = sa - 2 * half;
      if (ub >= hu) sb = sb - 2 * half;
      e.res = '0; e.c = 1'b0; e.v = 1'b0;
      case (sel)
         3'd0: begin
            full = ua + ub; e.res = full & mask; e.c = (full > mask);
            ss = sa + sb; e.v = (ss >= half) || (ss < -half);
         end
         3'd1: begin
            e.res = (ua - ub) & mask; e.c = (ua < ub);
            ss = sa - sb; e.v = (ss >= half) || (ss < -half);
         end
         3'd2: e.res = ua & ub;
         3'd3: e.res = ua | ub;
         3'd4: e.res = ua ^ ub;
         3'd5: e.res = (ua > ub) ? 64'd1 : 64'd0;
         3'd6: begin full = ua * ub; e.res = full & mask; e.v = (full > mask); end
         default: e.res = (ua << (ub % w)) & mask;
      endcase
      e.z = (e.res == 64'd0);
      return e;
   endfunction

   task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      int t = 0;
      q8.push_back(model(8, {56'd0, a}, {56'd0, b}, s));
      @(negedge clk); a8 = a; bb8 = b; s8 = s; iv8 = 1'b1;
      while (ir8 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      n_chk++;
      if (ir8 !== 1'b1) begin n_fail++; $display("FAIL accept8: in_ready=%b required 1", ir8); end
      @(posedge clk); #1 iv8 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
      int t = 0;
      q32.push_back(model(32, {32'd0, a}, {32'd0, b}, s));
      @(negedge clk); a32 = a; bb32 = b; s32 = s; iv32 = 1'b1;
      while (ir32 !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      n_chk++;
      if (ir32 !== 1'b1) begin n_fail++; $display("FAIL accept32: in_ready=%b required 1", ir32); end
      @(posedge clk); #1 iv32 = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      iv8 = 1'b0; a8 = '0; bb8 = '0; s8 = '0; ordy8 = 1'b1;
      iv32 = 1'b0; a32 = '0; bb32 = '0; s32 = '0; ordy32 = 1'b1;
      #12;
      n_chk++;
      if ({ov8, b8, res8, z8, c8, v8} !== 12'd0) begin
         n_fail++; $display("FAIL reset8_outs: got %h required 0", {ov8, b8, res8, z8, c8, v8});
      end
      n_chk++;
      if (ir8 !== 1'b1) begin n_fail++; $display("FAIL reset8_ready: got %b required 1", ir8); end
      n_chk++;
      if ({ov32, b32, res32, z32, c32, v32} !== 36'd0) begin
         n_fail++; $display("FAIL reset32_outs: got %h required 0", {ov32, b32, res32, z32, c32, v32});
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_add_sub;
      exp_t e;
      logic [7:0] av[2] = '{8'hFF, 8'h80};
      logic [7:0] bv[2] = '{8'h01, 8'h01};
      logic [2:0] sv[2] = '{3'd0, 3'd1};
      ordy8 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send8(av[i], bv[i], sv[i]);
         @(negedge clk);
         n_chk++;
         if (ov8 !== 1'b1) begin n_fail++; $display("FAIL addsub_latency%0d: out_valid=%b required 1", i, ov8); end
         e = q8.pop_front();
         n_chk++;
         if ({res8, z8, c8, v8} !== {e.res[7:0], e.z, e.c, e.v}) begin
            n_fail++;
            $display("FAIL addsub%0d: got res=%h z=%b c=%b v=%b required res=%h z=%b c=%b v=%b",
                     i, res8, z8, c8, v8, e.res[7:0], e.z, e.c, e.v);
         end
      end
   endtask

   task automatic test_mul;
      exp_t e;
      logic [7:0] av[2] = '{8'd13, 8'd20};
      logic [7:0] bv[2] = '{8'd11, 8'd20};
      ordy8 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send8(av[i], bv[i], 3'd6);
         for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_chk++;
            if ({b8, ov8} !== 2'b10) begin
               n_fail++; $display("FAIL mul_busy%0d_c%0d: busy,out_valid=%b required 10", i, j, {b8, ov8});
            end
         end
         @(negedge clk);
         n_chk++;
         if ({b8, ov8} !== 2'b01) begin
            n_fail++; $display("FAIL mul_done%0d: busy,out_valid=%b required 01", i, {b8, ov8});
         end
         e = q8.pop_front();
         n_chk++;
         if ({res8, z8, c8, v8} !== {e.res[7:0], e.z, e.c, e.v}) begin
            n_fail++;
            $display("FAIL mul%0d: got res=%h z=%b c=%b v=%b required res=%h z=%b c=%b v=%b",
                     i, res8, z8, c8, v8, e.res[7:0], e.z, e.c, e.v);
         end
      end
   endtask

   task automatic test_legacy;
      exp_t e;
      logic [2:0]  sv[5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
      logic [31:0] av, bv;
      ordy32 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         av = (sv[i] == 3'd7) ? 32'd1  : 32'hF0F0F0F0;
         bv = (sv[i] == 3'd7) ? 32'd31 : 32'h0FF00FF0;
         send32(av, bv, sv[i]);
         @(negedge clk);
         e = q32.pop_front();
         n_chk++;
         if ({ov32, res32, z32, c32, v32} !== {1'b1, e.res[31:0], e.z, e.c, e.v}) begin
            n_fail++;
            $display("FAIL legacy_sel%0d: got valid=%b res=%h z=%b c=%b v=%b required valid=1 res=%h z=%b c=%b v=%b",
                     sv[i], ov32, res32, z32, c32, v32, e.res[31:0], e.z, e.c, e.v);
         end
      end
   endtask

   task automatic test_backpressure;
      exp_t e;
      logic [10:0] snap;
      ordy8 = 1'b0;
      send8(8'd3, 8'd4, 3'd0);
      @(negedge clk);
      e = q8.pop_front();
      n_chk++;
      if ({ov8, res8, z8, c8, v8} !== {1'b1, e.res[7:0], e.z, e.c, e.v}) begin
         n_fail++; $display("FAIL bp_first: got valid=%b res=%h required valid=1 res=%h", ov8, res8, e.res[7:0]);
      end
      snap = {res8, z8, c8, v8};
      q8.push_back(model(8, 64'd9, 64'd9, 3'd0));
      a8 = 8'd9; bb8 = 8'd9; s8 = 3'd0; iv8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if ({res8, z8, c8, v8, ov8, ir8} !== {snap, 2'b10}) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got res/flags=%h valid=%b ready=%b required %h valid=1 ready=0",
                     i, {res8, z8, c8, v8}, ov8, ir8, snap);
         end
      end
      ordy8 = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({ov8, ir8} !== 2'b01) begin
         n_fail++; $display("FAIL bp_release: valid,ready=%b required 01", {ov8, ir8});
      end
      @(posedge clk); #1 iv8 = 1'b0;
      @(negedge clk);
      e = q8.pop_front();
      n_chk++;
      if ({ov8, res8, z8, c8, v8} !== {1'b1, e.res[7:0], e.z, e.c, e.v}) begin
         n_fail++; $display("FAIL bp_second: got valid=%b res=%h required valid=1 res=%h", ov8, res8, e.res[7:0]);
      end
   endtask

   task automatic test_mid_reset;
      exp_t e;
      int stale = 0;
      ordy8 = 1'b1;
      send8(8'd13, 8'd11, 3'd6);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({ov8, b8, res8, z8, c8, v8, ir8} !== 13'd1) begin
         n_fail++; $display("FAIL midrst_outs: got %h required 1", {ov8, b8, res8, z8, c8, v8, ir8});
      end
      q8.delete();
      @(negedge clk); rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (ov8 !== 1'b0 || ir8 !== 1'b1) stale++;
      end
      n_chk++;
      if (stale != 0) begin n_fail++; $display("FAIL midrst_stale: bad cycles=%0d required 0", stale); end
      send8(8'd2, 8'd3, 3'd0);
      @(negedge clk);
      e = q8.pop_front();
      n_chk++;
      if ({ov8, res8} !== {1'b1, e.res[7:0]}) begin
         n_fail++; $display("FAIL midrst_add: got valid=%b res=%h required valid=1 res=%h", ov8, res8, e.res[7:0]);
      end
   endtask

   task automatic test_input_change;
      exp_t e;
      ordy8 = 1'b1;
      send8(8'd200, 8'd3, 3'd6);
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         a8 = 8'($urandom); bb8 = 8'($urandom); s8 = 3'($urandom);
      end
      @(negedge clk);
      e = q8.pop_front();
      n_chk++;
      if ({ov8, res8, z8, c8, v8} !== {1'b1, e.res[7:0], e.z, e.c, e.v}) begin
         n_fail++;
         $display("FAIL mul_inchg: got valid=%b res=%h v=%b required valid=1 res=%h v=%b",
                  ov8, res8, v8, e.res[7:0], e.v);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      logic [31:0] av, bv;
      logic [2:0]  sv;
      int k, want;
      ordy32 = 1'b1;
      for (int i = 0; i < 24; i++) begin
         sv = 3'($urandom);
         av = $urandom;
         bv = (i % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
         if (i % 5 == 0) bv = av;
         send32(av, bv, sv);
         k = 0;
         do begin @(negedge clk); k++; end while (ov32 !== 1'b1 && k < 80);
         want = (sv == 3'd6) ? 33 : 1;
         n_chk++;
         if (k != want) begin n_fail++; $display("FAIL b2b_latency%0d: got %0d required %0d", i, k, want); end
         e = q32.pop_front();
         n_chk++;
         if ({ov32, res32, z32, c32, v32} !== {1'b1, e.res[31:0], e.z, e.c, e.v}) begin
            n_fail++;
            $display("FAIL b2b%0d sel=%0d: got valid=%b res=%h z=%b c=%b v=%b required valid=1 res=%h z=%b c=%b v=%b",
                     i, sv, ov32, res32, z32, c32, v32, e.res[31:0], e.z, e.c, e.v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul();
      test_legacy();
      test_backpressure();
      test_mid_reset();
      test_input_change();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
